crc8_check: RTL and testbench

- Receive-side counterpart of the crc8_byte generator: consumes a byte stream whose final byte is the transmitted CRC-8, recomputes the CRC bit-serially and flags pass/fail per frame.
- Same polynomial, init and MSB-first bit order as crc8_byte, so a frame of payload plus generated CRC leaves a zero residue.
- Sits on the receive path between byte deframer and packet consumer.

---
 rtl/crc8_pkg.sv | 25 ++
 rtl/crc8_bit_lfsr.sv | 43 ++++
 rtl/crc8_check.sv | 190 +++++++++++++++++++
 tb/tb_crc8_check.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the crc8_byte generator and the crc8_check receiver:
// default polynomial/init, FSM state encoding and the single-bit CRC update.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
    localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } crc8_state_e;

    // One MSB-first CRC step: feedback is the outgoing CRC bit xor the incoming data bit.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       din,
        input logic [7:0] poly
    );
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_bit_lfsr.sv
// Bit-serial CRC-8 register: load restores INIT, step folds in one data bit.
// Load has priority over step.
module crc8_bit_lfsr
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY = CRC8_POLY_DEFAULT,
    parameter logic [7:0] INIT = CRC8_INIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       step,
    input  logic       din,
    output logic [7:0] crc
);

    logic [7:0] crc_d;
    logic [7:0] crc_q;

    // Next CRC value from load/step controls.
    always_comb begin
        crc_d = crc_q;
        if (load) begin
            crc_d = INIT;
        end else if (step) begin
            crc_d = crc8_step(crc_q, din, POLY);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc8_check.sv
// Receive-side CRC-8 checker: shifts each byte through the CRC one bit per cycle and
// reports the residue of every frame. Optional frame length/runt reporting: CRC8_CHECK_LEN_EN.
module crc8_check
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLY  = CRC8_POLY_DEFAULT,
    parameter logic [7:0] INIT  = CRC8_INIT_DEFAULT,
    parameter int         LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic [7:0]       residue
`ifdef CRC8_CHECK_LEN_EN
    ,
    output logic [LEN_W-1:0] frame_len,
    output logic             runt
`endif
);

    if (LEN_W < 1) begin : g_len_w_check
        $error("crc8_check: LEN_W must be at least 1");
    end

    crc8_state_e state_d, state_q;
    logic [7:0]  sh_d, sh_q;
    logic        last_d, last_q;
    logic [2:0]  bitcnt_d, bitcnt_q;
    logic        done_d, done_q;
    logic        ok_d, ok_q;
    logic        err_d, err_q;
    logic [7:0]  res_d, res_q;
    logic [7:0]  crc_s;
    logic        lfsr_load_s;
    logic        lfsr_step_s;

    assign in_ready    = (state_q == IDLE) && !clr && !rst;
    assign lfsr_load_s = clr || (state_q == CHECK);
    assign lfsr_step_s = (state_q == SHIFT) && !clr;

    crc8_bit_lfsr #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load_s),
        .step (lfsr_step_s),
        .din  (sh_q[7]),
        .crc  (crc_s)
    );

    // Frame FSM next-state and status capture.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        last_d   = last_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;
        res_d    = res_q;
        if (clr) begin
            state_d = IDLE;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            res_d   = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_d     = in_data;
                        last_d   = in_last;
                        bitcnt_d = 3'd7;
                        state_d  = SHIFT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                SHIFT: begin
                    sh_d     = {sh_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q - 3'd1;
                    if (bitcnt_q == 3'd0) begin
                        state_d = last_q ? CHECK : IDLE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
                CHECK: begin
                    done_d  = 1'b1;
                    res_d   = crc_s;
                    ok_d    = (crc_s == 8'h00);
                    err_d   = (crc_s != 8'h00);
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sh_q     <= 8'h00;
            last_q   <= 1'b0;
            bitcnt_q <= 3'd0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            last_q   <= last_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            res_q    <= res_d;
        end
    end

    assign done    = done_q;
    assign crc_ok  = ok_q;
    assign crc_err = err_q;
    assign residue = res_q;

`ifdef CRC8_CHECK_LEN_EN
    logic [LEN_W-1:0] len_d, len_q;
    logic [LEN_W-1:0] flen_d, flen_q;
    logic             runt_d, runt_q;

    // Byte counter saturates so oversized frames report all-ones rather than wrapping.
    always_comb begin
        len_d  = len_q;
        flen_d = flen_q;
        runt_d = runt_q;
        if (clr) begin
            len_d  = '0;
            flen_d = '0;
            runt_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && (len_q != {LEN_W{1'b1}})) begin
                        len_d = len_q + LEN_W'(1);
                    end else begin
                        len_d = len_q;
                    end
                end
                CHECK: begin
                    flen_d = len_q;
                    runt_d = (len_q == LEN_W'(1));
                    len_d  = '0;
                end
                default: begin
                    len_d = len_q;
                end
            endcase
        end
    end

    // Frame length registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            flen_q <= '0;
            runt_q <= 1'b0;
        end else begin
            len_q  <= len_d;
            flen_q <= flen_d;
            runt_q <= runt_d;
        end
    end

    assign frame_len = flen_q;
    assign runt      = runt_q;
`endif

endmodule

// File: tb/tb_crc8_check.sv
// Directed bench for crc8_check: a bit-serial reference model fills a scoreboard of
// expected frame results that are popped whenever the DUT pulses done.
module tb_crc8_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       done;
    logic       crc_ok;
    logic       crc_err;
    logic [7:0] residue;
`ifdef CRC8_CHECK_LEN_EN
    logic [7:0] frame_len;
    logic       runt;
`endif

    crc8_check dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .done     (done),
        .crc_ok   (crc_ok),
        .crc_err  (crc_err),
        .residue  (residue)
`ifdef CRC8_CHECK_LEN_EN
        ,
        .frame_len(frame_len),
        .runt     (runt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic       ok;
        logic       err;
        logic [7:0] len;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic seen_done;

    function automatic logic [7:0] crc_model(input logic [7:0] bytes[$]);
        logic [7:0] c;
        logic       m;
        c = 8'h00;
        foreach (bytes[i]) begin
            for (int k = 7; k >= 0; k--) begin
                m = c[7] ^ bytes[i][k];
                c = {c[6:0], 1'b0};
                if (m) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            seen_done = 1'b1;
            chk("done_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("residue", {24'd0, residue}, {24'd0, e.res});
                chk("crc_ok", {31'd0, crc_ok}, {31'd0, e.ok});
                chk("crc_err", {31'd0, crc_err}, {31'd0, e.err});
`ifdef CRC8_CHECK_LEN_EN
                chk("frame_len", {24'd0, frame_len}, {24'd0, e.len});
                chk("runt", {31'd0, runt}, {31'd0, (e.len == 8'd1)});
`endif
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic last, output int n);
        logic acc;
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            #1;
            acc = in_ready;
            tick();
            n++;
        end
        chk("accept_within_budget", {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends a frame with in_valid held; returns cycles taken to accept the first byte.
    task automatic send_frame(input logic [7:0] bytes[$], input logic push, output int first_n);
        exp_t e;
        int   n;
        e.res = crc_model(bytes);
        e.ok  = (e.res == 8'h00);
        e.err = (e.res != 8'h00);
        e.len = 8'(bytes.size());
        if (push) exp_q.push_back(e);
        first_n = 0;
        foreach (bytes[i]) begin
            send(bytes[i], (i == bytes.size() - 1), n);
            if (i == 0) first_n = n;
            else chk("byte_spacing", n, 32'd9);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        seen_done = 1'b0;
        while (!seen_done && n < 40) begin
            tick();
            n++;
        end
        chk("done_latency", n, 32'd9);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_ok"}, {31'd0, crc_ok}, 32'd0);
        chk({tag, "_err"}, {31'd0, crc_err}, 32'd0);
        chk({tag, "_residue"}, {24'd0, residue}, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
        seen_done = 1'b0;
        tick(); tick();
        chk_cleared("reset");
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        send_frame('{8'hAE, 8'h43}, 1'b1, n);
        chk("first_accept", n, 32'd1);
        wait_done();
        chk("ok_holds", {31'd0, crc_ok}, 32'd1);

        send_frame('{8'hAE, 8'h0F, 8'hE3}, 1'b1, n);
        wait_done();
        send_frame('{8'hAE, 8'h0F, 8'hE2}, 1'b1, n);
        wait_done();
        chk("err_holds", {31'd0, crc_err}, 32'd1);
        send_frame('{8'h0F}, 1'b1, n);
        wait_done();

        // Back-to-back frames: the next frame's first byte waits out the CHECK cycle.
        send_frame('{8'hAE, 8'h43}, 1'b1, n);
        send_frame('{8'hAE, 8'h0F, 8'hE3}, 1'b1, n);
        chk("b2b_first_accept", n, 32'd10);
        wait_done();

        // Abort a frame mid-shift with clr.
        send(8'hAE, 1'b0, n);
        tick(); tick(); tick();
        clr = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        #1 chk("clr_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk_cleared("clr");
        send_frame('{8'h0F, 8'h2D}, 1'b1, n);
        chk("post_clr_accept", n, 32'd1);
        wait_done();

        // Reset during SHIFT, after leaving an error status behind.
        send_frame('{8'h0F}, 1'b1, n);
        wait_done();
        send(8'hAE, 1'b0, n);
        tick(); tick(); tick();
        rst = 1'b1;
        #1 chk("rst_shift_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk_cleared("rst_shift");
        rst = 1'b0;
        #1 chk("rst_shift_ready_after", {31'd0, in_ready}, 32'd1);

        // Reset while in CHECK: no done may follow.
        send(8'h0F, 1'b1, n);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        chk_cleared("rst_check");
        tick();
        chk("rst_check_no_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        #1 chk("rst_check_ready_after", {31'd0, in_ready}, 32'd1);

        send_frame('{8'hAE, 8'h43}, 1'b1, n);
        wait_done();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
